// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and width helper for the serial pattern detector
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNARMED = 2'd0,
        FILL    = 2'd1,
        HUNT    = 2'd2
    } seq_state_t;

    // Width needed to hold a fill level from 0 up to and including pat_w.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable serial pattern detector with saturating match count
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8,
    parameter int FILL_W = fill_width(PAT_W)
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              load,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    input  logic              bit_valid,
    input  logic              serial_in,
    output logic              match,
    output logic [CNT_W-1:0]  match_count,
    output logic              armed,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    seq_state_t        state_q, state_d;
    logic [PAT_W-1:0]  pat_q;
    logic [PAT_W-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;

    logic              consume;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_next;
    logic              hit;

    always_comb begin
        consume   = 1'b0;
        hist_next = '0;
        fill_next = '0;
        hit       = 1'b0;
        state_d   = state_q;

        // load outranks bit_valid, so a bit presented with load is never consumed
        consume   = (state_q != UNARMED) && bit_valid && !load;
        hist_next = (hist_q << 1) | {{(PAT_W-1){1'b0}}, serial_in};
        fill_next = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit       = consume && (hist_next == pat_q) && (fill_next == FILL_FULL);

        if (load) begin
            state_d = FILL;
        end else if (consume) begin
            if (hit && !overlap) begin
                state_d = FILL;
            end else if (fill_next == FILL_FULL) begin
                state_d = HUNT;
            end else begin
                state_d = FILL;
            end
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state_q     <= UNARMED;
            pat_q       <= '0;
            hist_q      <= '0;
            fill_q      <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (load) begin
            state_q     <= state_d;
            pat_q       <= pattern;
            hist_q      <= '0;
            fill_q      <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            state_q <= state_d;
            match   <= hit;
            if (consume) begin
                if (hit && !overlap) begin
                    hist_q <= '0;
                    fill_q <= '0;
                end else begin
                    hist_q <= hist_next;
                    fill_q <= fill_next;
                end
            end
            if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    assign armed = (state_q != UNARMED);
    assign fill  = fill_q;

endmodule
